// File: rtl/alu_operand_arbiter.sv
// Four-requester arbiter that owns the ALU operand mux and feeds a 1-deep registered output stage.
// Build option: define ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module alu_operand_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              in_valid,
  input  logic [4*DATA_WIDTH-1:0] in_data,
  output logic [3:0]              in_ready,
  output logic [1:0]              mux_sel,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [1:0]              out_src,
  input  logic                    out_ready,
  output logic [CNT_WIDTH-1:0]    xfer_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0]            src_q, src_d;
  logic [1:0]            rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0]  cnt_q;

  logic [1:0] scan_base;
  logic [3:0] rotated;
  logic [1:0] offset;
  logic [1:0] winner;
  logic       any_req;
  logic       load;
  logic       take;

`ifdef ARB_FIXED_PRIO_EN
  assign scan_base = 2'd0;
`else
  assign scan_base = rr_ptr_q;
`endif

  // Rotate requests so the highest-priority requester lands at bit 0, then pick the first set bit.
  always_comb begin
    rotated = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      rotated[k] = in_valid[2'(scan_base + 2'(k))];
    end
    offset = 2'd0;
    if (rotated[0])      offset = 2'd0;
    else if (rotated[1]) offset = 2'd1;
    else if (rotated[2]) offset = 2'd2;
    else if (rotated[3]) offset = 2'd3;
  end

  assign winner  = scan_base + offset;
  assign any_req = |in_valid;
  assign load    = (state_q == EMPTY) || out_ready;
  assign take    = load && any_req;

  assign in_ready = (rst_n && take) ? (4'b0001 << winner) : 4'b0000;
  assign mux_sel  = !rst_n ? 2'd0 : (any_req ? winner : rr_ptr_q);

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    src_d    = src_q;
    rr_ptr_d = rr_ptr_q;
    if (take) begin
      state_d = FULL;
      data_d  = in_data[winner*DATA_WIDTH +: DATA_WIDTH];
      src_d   = winner;
`ifdef ARB_FIXED_PRIO_EN
      rr_ptr_d = 2'd0;
`else
      rr_ptr_d = winner + 2'd1;
`endif
    end else if (load) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      data_q   <= '0;
      src_q    <= 2'd0;
      rr_ptr_q <= 2'd0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      src_q    <= src_d;
      rr_ptr_q <= rr_ptr_d;
      if ((state_q == FULL) && out_ready) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_alu_operand_arbiter.sv
// Scoreboard bench for alu_operand_arbiter; a second instance with a 4-bit counter covers wrap-around.
// Compile with ARB_FIXED_PRIO_EN to exercise the fixed-priority build.
module tb_alu_operand_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   inValid;
  logic [127:0] inData;
  logic         outReady;

  logic [3:0]   inReady,  inReady4;
  logic [1:0]   muxSel,   muxSel4;
  logic         outValid, outValid4;
  logic [31:0]  outData,  outData4;
  logic [1:0]   outSrc,   outSrc4;
  logic [15:0]  xferCnt;
  logic [3:0]   xferCnt4;

  typedef struct packed {
    logic [1:0]  src;
    logic [31:0] data;
  } sbEntry_t;

  sbEntry_t    sb[$];
  logic [1:0]  modelPtr;
  logic [15:0] modelCnt;
  int          checkCount;
  int          errorCount;

  alu_operand_arbiter #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_data(inData),
    .in_ready(inReady), .mux_sel(muxSel), .out_valid(outValid),
    .out_data(outData), .out_src(outSrc), .out_ready(outReady), .xfer_cnt(xferCnt)
  );

  alu_operand_arbiter #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_data(inData),
    .in_ready(inReady4), .mux_sel(muxSel4), .out_valid(outValid4),
    .out_data(outData4), .out_src(outSrc4), .out_ready(outReady), .xfer_cnt(xferCnt4)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if the observed value differs from the expected one.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Reference arbitration: walk the rotation from the pointer and take the first requester seen.
  function automatic logic [1:0] modelWinner(input logic [3:0] v, input logic [1:0] ptr);
    int p;
    p = int'(ptr);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return 2'((p + k) % 4);
    end
    return ptr;
  endfunction

  // Drive one cycle of inputs, check combinational and registered outputs, then advance the model.
  task automatic applyStimulus(input logic [3:0] vld, input logic [127:0] dAll, input logic ordy,
                               output logic [3:0] granted);
    logic       expValid;
    logic       load;
    logic [1:0] win;
    logic [3:0] expReady;
    logic [1:0] expSel;
    @(negedge clk);
    inValid  = vld;
    inData   = dAll;
    outReady = ordy;
    #1;
    expValid = (sb.size() != 0);
    load     = !expValid || ordy;
    win      = modelWinner(vld, modelPtr);
    expReady = (load && (vld != 4'b0000)) ? (4'b0001 << win) : 4'b0000;
    expSel   = (vld != 4'b0000) ? win : modelPtr;
    checkOutput("in_ready", 64'(inReady), 64'(expReady));
    checkOutput("in_ready_c4", 64'(inReady4), 64'(expReady));
    checkOutput("mux_sel", 64'(muxSel), 64'(expSel));
    checkOutput("out_valid", 64'(outValid), 64'(expValid));
    checkOutput("out_valid_c4", 64'(outValid4), 64'(expValid));
    if (expValid) begin
      checkOutput("out_data", 64'(outData), 64'(sb[0].data));
      checkOutput("out_src", 64'(outSrc), 64'(sb[0].src));
      checkOutput("out_src_c4", 64'(outSrc4), 64'(sb[0].src));
    end
    checkOutput("xfer_cnt", 64'(xferCnt), 64'(modelCnt));
    checkOutput("xfer_cnt_c4", 64'(xferCnt4), 64'(modelCnt[3:0]));
    granted = expReady;
    if (expValid && ordy) begin
      void'(sb.pop_front());
      modelCnt = modelCnt + 16'd1;
    end
    if (load && (vld != 4'b0000)) begin
      sb.push_back('{src: win, data: dAll[int'(win)*32 +: 32]});
`ifdef ARB_FIXED_PRIO_EN
      modelPtr = 2'd0;
`else
      modelPtr = win + 2'd1;
`endif
    end
  endtask

  initial begin
    logic [3:0]   g;
    logic [3:0]   pending;
    logic [127:0] pdata;
    logic [127:0] rrData;

    checkCount = 0;
    errorCount = 0;
    modelPtr   = 2'd0;
    modelCnt   = 16'd0;
    rst_n      = 1'b0;
    inValid    = 4'b1111;
    inData     = '0;
    outReady   = 1'b1;
    rrData     = {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};

    // Outputs must be quiet while reset is held, even with requests pending.
    #2;
    checkOutput("rst_out_valid", 64'(outValid), 64'(0));
    checkOutput("rst_in_ready", 64'(inReady), 64'(0));
    checkOutput("rst_mux_sel", 64'(muxSel), 64'(0));
    checkOutput("rst_xfer_cnt", 64'(xferCnt), 64'(0));
    checkOutput("rst_out_data", 64'(outData), 64'(0));
    checkOutput("rst_out_src", 64'(outSrc), 64'(0));
    inValid = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request from requester 2; then hold it in the output stage.
    applyStimulus(4'b0100, {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0000_0000}, 1'b1, g);
    applyStimulus(4'b0000, '0, 1'b0, g);
    applyStimulus(4'b0000, '0, 1'b0, g);

    // Asynchronous reset mid-cycle while the stage is full.
    @(negedge clk);
    inValid  = 4'b1111;
    outReady = 1'b1;
    #2;
    checkOutput("pre_rst_valid", 64'(outValid), 64'(1));
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_out_valid", 64'(outValid), 64'(0));
    checkOutput("async_rst_xfer_cnt", 64'(xferCnt), 64'(0));
    checkOutput("async_rst_in_ready", 64'(inReady), 64'(0));
    checkOutput("async_rst_mux_sel", 64'(muxSel), 64'(0));
    sb.delete();
    modelPtr = 2'd0;
    modelCnt = 16'd0;
    inValid  = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;

    // Full load: every requester asserted, one transfer per cycle.
    for (int i = 0; i < 5; i++) applyStimulus(4'b1111, rrData, 1'b1, g);
    applyStimulus(4'b0000, '0, 1'b1, g);
    @(negedge clk);
    #1;
    checkOutput("rr_xfer_cnt_5", 64'(xferCnt), 64'(5));

    // Backpressure: fill, stall three cycles, then drain and refill on the same edge.
    applyStimulus(4'b0011, rrData, 1'b0, g);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0011 & ~g, rrData, 1'b0, g);
    pending = 4'b0011;
    applyStimulus(4'b0001, rrData, 1'b1, g);
    applyStimulus(4'b0000, '0, 1'b1, g);
    applyStimulus(4'b0000, '0, 1'b1, g);

`ifdef ARB_FIXED_PRIO_EN
    // Requester 1 keeps re-requesting and must always beat requester 3.
    for (int i = 0; i < 6; i++) applyStimulus(4'b1010, rrData, 1'b1, g);
    applyStimulus(4'b0000, '0, 1'b1, g);
`endif

    // Random traffic: requesters hold until granted, random backpressure.
    pending = 4'b0000;
    pdata   = '0;
    for (int n = 0; n < 400; n++) begin
      for (int r = 0; r < 4; r++) begin
        if (!pending[r] && ($urandom_range(0, 9) < 5)) begin
          pending[r]          = 1'b1;
          pdata[r*32 +: 32]   = $urandom;
        end
      end
      applyStimulus(pending, pdata, ($urandom_range(0, 3) != 0), g);
      pending = pending & ~g;
    end
    applyStimulus(4'b0000, '0, 1'b1, g);
    applyStimulus(4'b0000, '0, 1'b1, g);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
